// File: rtl/div_repsub_if.sv
// div_repsub_if: operand/result bundle between the divider and its requester.
interface div_repsub_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             busy;
    logic             div_by_zero;
    modport master (output start, data_in, input quotient, remainder, done, busy, div_by_zero);
    modport slave  (input start, data_in, output quotient, remainder, done, busy, div_by_zero);
endinterface

// File: rtl/div_repsub.sv
// div_repsub: unsigned repeated-subtraction divider, operands loaded serially on one bus.
module div_repsub #(parameter int WIDTH = 16) (
    input logic        clk,
    input logic        rst,
    div_repsub_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LD_A, LD_B, SUB, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, q_q, q_d;
    logic             dz_q, dz_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            dz_q    <= dz_d;
        end
    end
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: state_d = bus.start ? LD_A : IDLE;
            LD_A: begin
                a_d     = bus.data_in;
                state_d = LD_B;
            end
            LD_B: begin
                b_d     = bus.data_in;
                q_d     = '0;
                dz_d    = (bus.data_in == '0);
                state_d = SUB;
            end
            SUB: begin
                // A zero divisor saturates the quotient and leaves the dividend as remainder
                if (b_q == '0) begin
                    q_d     = '1;
                    state_d = DONE;
                end else if (a_q >= b_q) begin
                    a_d = a_q - b_q;
                    q_d = q_q + WIDTH'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: state_d = bus.start ? LD_A : DONE;
            default: state_d = IDLE;
        endcase
    end
    assign bus.quotient    = q_q;
    assign bus.remainder   = a_q;
    assign bus.div_by_zero = dz_q;
    assign bus.done        = (state_q == DONE);
    assign bus.busy        = (state_q == LD_A) || (state_q == LD_B) || (state_q == SUB);
endmodule

// File: tb/tb_div_repsub.sv
// tb_div_repsub: directed and random divisions checked against plain-arithmetic expectations.
module tb_div_repsub;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    div_repsub_if #(.WIDTH(W)) bus();
    div_repsub #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one operation from a negedge; expected results come from integer / and %.
    task automatic run_op(input int a, input int b, input bit noise);
        int edges = 0;
        int busy_n = 0;
        int exp_q, exp_r, exp_e;
        exp_q = (b == 0) ? 65535 : a / b;
        exp_r = (b == 0) ? a : a % b;
        exp_e = (b == 0) ? 4 : 4 + a / b;
        bus.start   = 1'b1;
        bus.data_in = W'($urandom);
        while (1) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.done === 1'b1 || edges > exp_e + 8) break;
            busy_n += (bus.busy === 1'b1) ? 1 : 0;
            bus.start   = noise ? 1'($urandom) : 1'b0;
            bus.data_in = (edges == 1) ? W'(a) : (edges == 2) ? W'(b) : W'($urandom);
        end
        bus.start = 1'b0;
        chk($sformatf("edges %0d/%0d", a, b), edges, exp_e);
        chk($sformatf("quotient %0d/%0d", a, b), 32'(bus.quotient), exp_q);
        chk($sformatf("remainder %0d/%0d", a, b), 32'(bus.remainder), exp_r);
        chk($sformatf("dz %0d/%0d", a, b), 32'(bus.div_by_zero), 32'(b == 0));
        chk($sformatf("busy_cycles %0d/%0d", a, b), busy_n, exp_e - 1);
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = '0;
        #12;
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_quotient", 32'(bus.quotient), 0);
        chk("rst_remainder", 32'(bus.remainder), 0);
        chk("rst_dz", 32'(bus.div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(100, 7, 1'b0);
        run_op(7, 100, 1'b0);
        run_op(0, 0, 1'b0);
        run_op(9, 3, 1'b0);
        run_op(65535, 1, 1'b1);
        repeat (5) @(negedge clk);
        chk("done_held", 32'(bus.done), 1);
        chk("quotient_held", 32'(bus.quotient), 65535);
        chk("remainder_held", 32'(bus.remainder), 0);
        bus.start   = 1'b1;
        bus.data_in = W'($urandom);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.data_in = W'(1000);
        @(negedge clk);
        bus.data_in = W'(3);
        repeat (20) @(negedge clk);
        chk("busy_mid_sub", 32'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_done", 32'(bus.done), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_quotient", 32'(bus.quotient), 0);
        chk("arst_remainder", 32'(bus.remainder), 0);
        chk("arst_dz", 32'(bus.div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_done", 32'(bus.done), 0);
        run_op(1000, 3, 1'b0);
        run_op(50, 5, 1'b0);
        run_op(51, 5, 1'b0);
        for (int i = 0; i < 30; i++) begin
            int a, b;
            case ($urandom_range(0, 3))
                0: begin a = $urandom_range(0, 400); b = $urandom_range(0, 20); end
                1: begin a = $urandom_range(0, 65535); b = $urandom_range(256, 65535); end
                2: begin a = $urandom_range(0, 65535); b = 0; end
                default: begin a = $urandom_range(1, 65535); b = a; end
            endcase
            run_op(a, b, 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
